// File: rtl/raw_frame_ctrl_if.sv
// ============================================================================
// Module      : raw_frame_ctrl_if
// Description : 24-bit Avalon-ST video sink bundle for the RGB-to-Bayer
//               frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface raw_frame_ctrl_if;
    logic [23:0] sink_data;
    logic        sink_valid;
    logic        sink_sop;
    logic        sink_eop;
    logic        sink_ready;

    modport master (
        output sink_data,
        output sink_valid,
        output sink_sop,
        output sink_eop,
        input  sink_ready
    );

    modport slave (
        input  sink_data,
        input  sink_valid,
        input  sink_sop,
        input  sink_eop,
        output sink_ready
    );
endinterface

`default_nettype wire

// File: rtl/raw_frame_ctrl.sv
// ============================================================================
// Module      : raw_frame_ctrl
// Description : Frame sequencer for the RGB-to-Bayer path. Sorts video from
//               control packets, tracks pixel x/y, drives the datapath enable,
//               Bayer select and frame boundaries, and flags short/long frames.
//               Optional statistics counters: RAW_FRAME_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raw_frame_ctrl #(
    parameter int         WIDTH  = 1920,
    parameter int         HEIGHT = 1080,
    parameter logic [1:0] PHASE  = 2'b00
) (
    input  logic                  clk,
    input  logic                  rst,
    raw_frame_ctrl_if.slave       sink,
    input  logic                  source_ready,
    output logic                  dp_en,
    output logic [1:0]            dp_sel,
    output logic                  dp_sop,
    output logic                  dp_eop,
    output logic                  frame_done,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt
);

    localparam logic [15:0] C_X_LAST = 16'(WIDTH - 1);
    localparam logic [15:0] C_Y_LAST = 16'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VIDEO = 2'd1,
        CTRL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic        r_dp_en, r_dp_sop, r_dp_eop, r_frame_done, r_err_short, r_err_long;
    logic [1:0]  r_dp_sel;
    logic        w_dp_en, w_dp_sop, w_dp_eop, w_frame_done, w_err_short, w_err_long;
    logic [1:0]  w_dp_sel;
    logic        w_ready, w_acc, w_hdr, w_last;

    // Upper header bits carry nothing this block needs.
    logic w_unused_data;
    assign w_unused_data = ^sink.sink_data[23:4];

    // CTRL and DRAIN beats are discarded, so they never wait on the datapath.
    assign w_ready = ((r_state == IDLE) || (r_state == VIDEO)) ? source_ready : 1'b1;
    assign w_acc   = sink.sink_valid & w_ready;
    assign w_hdr   = w_acc & sink.sink_sop & ((r_state == IDLE) || (r_state == VIDEO));
    assign w_last  = (r_x == C_X_LAST) && (r_y == C_Y_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_dp_en      = 1'b0;
        w_dp_sel     = 2'b00;
        w_dp_sop     = 1'b0;
        w_dp_eop     = 1'b0;
        w_frame_done = 1'b0;
        w_err_short  = 1'b0;
        w_err_long   = 1'b0;

        if (w_hdr) begin
            // A header inside a frame truncates it, then decodes like any header.
            w_x_nxt = 16'd0;
            w_y_nxt = 16'd0;
            if (r_state == VIDEO) begin
                w_err_short = 1'b1;
            end
            if (sink.sink_data[3:0] == 4'd0) begin
                if (sink.sink_eop) begin
                    w_err_short = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = VIDEO;
                end
            end else begin
                w_state_nxt = sink.sink_eop ? IDLE : CTRL;
            end
        end else if (w_acc) begin
            case (r_state)
                VIDEO: begin
                    w_dp_en  = 1'b1;
                    w_dp_sel = {r_x[0] ^ PHASE[0], r_y[0] ^ PHASE[1]};
                    w_dp_sop = (r_x == 16'd0) && (r_y == 16'd0);
                    w_dp_eop = sink.sink_eop | w_last;
                    if (w_last) begin
                        if (sink.sink_eop) begin
                            w_frame_done = 1'b1;
                            w_state_nxt  = IDLE;
                        end else begin
                            w_err_long  = 1'b1;
                            w_state_nxt = DRAIN;
                        end
                    end else if (sink.sink_eop) begin
                        w_err_short = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_x == C_X_LAST) begin
                        w_x_nxt = 16'd0;
                        w_y_nxt = r_y + 16'd1;
                    end else begin
                        w_x_nxt = r_x + 16'd1;
                    end
                end
                CTRL, DRAIN: begin
                    if (sink.sink_eop) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x          <= 16'd0;
            r_y          <= 16'd0;
            r_dp_en      <= 1'b0;
            r_dp_sel     <= 2'b00;
            r_dp_sop     <= 1'b0;
            r_dp_eop     <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_dp_en      <= w_dp_en;
            r_dp_sel     <= w_dp_sel;
            r_dp_sop     <= w_dp_sop;
            r_dp_eop     <= w_dp_eop;
            r_frame_done <= w_frame_done;
            r_err_short  <= w_err_short;
            r_err_long   <= w_err_long;
        end
    end

`ifdef RAW_FRAME_CTRL_STATS_EN
    logic [15:0] r_frame_cnt, r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
            r_err_cnt   <= 16'd0;
        end else begin
            if (r_frame_done && (r_frame_cnt != 16'hFFFF)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if ((r_err_short || r_err_long) && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_cnt = 16'd0;
    assign err_cnt   = 16'd0;
`endif

    assign sink.sink_ready = w_ready;
    assign dp_en           = r_dp_en;
    assign dp_sel          = r_dp_sel;
    assign dp_sop          = r_dp_sop;
    assign dp_eop          = r_dp_eop;
    assign frame_done      = r_frame_done;
    assign err_short       = r_err_short;
    assign err_long        = r_err_long;
    assign busy            = (r_state != IDLE);

endmodule

`default_nettype wire
